// File: rtl/linreg_pkg.sv
// Shared definitions for the linear-regression datapath (loader, RAM, SGD).
// Holds the default geometry parameters, the common FSM state encoding and a
// small helper used to clamp the feature count.
package linreg_pkg;

  localparam int unsigned ADDR_WIDTH_DEF   = 12;
  localparam int unsigned MAX_FEATURES_DEF = 15;
  localparam int unsigned LENGTH_DEF       = 16;
  localparam int unsigned DEPTH_DEF        = 100;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t LOAD = 2'd1;
  localparam state_t DONE = 2'd2;

  // Feature counts beyond what the row can hold saturate at the row capacity.
  function automatic logic [3:0] clamp_feat(input logic [3:0] f, input int unsigned max_f);
    return (32'(f) > max_f) ? 4'(max_f) : f;
  endfunction

endpackage

// File: rtl/ser_word_shift.sv
// Serial-to-parallel word assembler.
// Ports:
//   clk, rst   - rising-edge clock, synchronous active-high reset
//   clr        - synchronous clear of the partial word and bit count
//   valid      - bit_in is taken on this cycle
//   bit_in     - serial bit, MSB first
//   word       - the word as it would stand after taking bit_in
//   word_done  - high in the cycle the LENGTH-th bit is taken; word is then complete
module ser_word_shift #(
  parameter int unsigned LENGTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              valid,
  input  logic              bit_in,
  output logic [LENGTH-1:0] word,
  output logic              word_done
);

  localparam int unsigned CntW = (LENGTH > 1) ? $clog2(LENGTH) : 1;

  // Only LENGTH-1 bits need storing: the final bit comes straight from bit_in.
  logic [LENGTH-2:0] shift_q;
  logic [CntW-1:0]   cnt_q;

  assign word      = {shift_q, bit_in};
  assign word_done = valid && (cnt_q == CntW'(LENGTH - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (valid) begin
      shift_q <= word[LENGTH-2:0];
      cnt_q   <= word_done ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/ser_row_loader.sv
// Serial row loader: assembles MSB-first serial words into rows of
// (feat feature words + one y word) and writes each row into a RAM.
// Ports:
//   CLK, RST   - rising-edge clock, synchronous active-high reset
//   start      - one-cycle pulse; samples feat and num_dp and begins a load
//   ser_in     - serial data bit, taken when ser_valid is high during LOAD
//   ser_valid  - qualifies ser_in
//   feat       - number of feature words per row (slot feat holds y)
//   num_dp     - number of rows to load; 0 or above DEPTH flags err
//   data, addr - completed row and its row index, stable except when we pulses
//   we         - one-cycle RAM write strobe
//   busy       - high while loading
//   done, err  - load finished / illegal num_dp; held until the next start
module ser_row_loader
  import linreg_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = ADDR_WIDTH_DEF,
  parameter int unsigned MAX_FEATURES = MAX_FEATURES_DEF,
  parameter int unsigned LENGTH       = LENGTH_DEF,
  parameter int unsigned DATA_WIDTH   = LENGTH * (MAX_FEATURES + 1),
  parameter int unsigned DEPTH        = DEPTH_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start,
  input  logic                  ser_in,
  input  logic                  ser_valid,
  input  logic [3:0]            feat,
  input  logic [ADDR_WIDTH-1:0] num_dp,
  output logic [DATA_WIDTH-1:0] data,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  we,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam logic [ADDR_WIDTH:0] DepthLim = (ADDR_WIDTH + 1)'(DEPTH);

  state_t                state_q;
  logic [3:0]            feat_q;
  logic [ADDR_WIDTH-1:0] num_dp_q;
  logic [ADDR_WIDTH-1:0] row_idx_q;
  logic [3:0]            word_idx_q;
  logic [DATA_WIDTH-1:0] row_q;
  logic [DATA_WIDTH-1:0] row_next;
  logic [DATA_WIDTH-1:0] data_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  we_q;
  logic                  err_q;

  logic                  accept_start;
  logic                  num_bad;
  logic                  last_row;
  logic                  shift_valid;
  logic [LENGTH-1:0]     word;
  logic                  word_done;

  assign accept_start = start && (state_q != LOAD);
  assign num_bad      = (num_dp == '0) || ({1'b0, num_dp} > DepthLim);
  assign last_row     = (row_idx_q == num_dp_q - ADDR_WIDTH'(1));
  assign shift_valid  = ser_valid && (state_q == LOAD);

  assign data = data_q;
  assign addr = addr_q;
  assign we   = we_q;
  assign busy = (state_q == LOAD);
  assign done = (state_q == DONE);
  assign err  = err_q;

  ser_word_shift #(
    .LENGTH(LENGTH)
  ) u_shift (
    .clk      (CLK),
    .rst      (RST),
    .clr      (accept_start),
    .valid    (shift_valid),
    .bit_in   (ser_in),
    .word     (word),
    .word_done(word_done)
  );

  // Row with the word that is just completing dropped into its slot.
  always_comb begin
    row_next = row_q;
    row_next[LENGTH*word_idx_q +: LENGTH] = word;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      feat_q     <= '0;
      num_dp_q   <= '0;
      row_idx_q  <= '0;
      word_idx_q <= '0;
      row_q      <= '0;
      data_q     <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            feat_q     <= clamp_feat(feat, MAX_FEATURES);
            num_dp_q   <= num_dp;
            row_idx_q  <= '0;
            word_idx_q <= '0;
            row_q      <= '0;
            if (num_bad) begin
              state_q <= DONE;
              err_q   <= 1'b1;
              addr_q  <= '0;
            end else begin
              state_q <= LOAD;
              err_q   <= 1'b0;
            end
          end
        end
        LOAD: begin
          // Retire the row just written; the index stops at the last row.
          if (we_q) begin
            row_q <= '0;
            if (last_row) begin
              state_q <= DONE;
            end else begin
              row_idx_q <= row_idx_q + ADDR_WIDTH'(1);
            end
          end
          // A word cannot complete in the we cycle, so this never races the clear.
          if (word_done) begin
            if (word_idx_q == feat_q) begin
              data_q     <= row_next;
              addr_q     <= row_idx_q;
              we_q       <= 1'b1;
              word_idx_q <= '0;
            end else begin
              row_q      <= row_next;
              word_idx_q <= word_idx_q + 4'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ser_row_loader.sv
module tb_ser_row_loader;

  localparam int L  = 16;
  localparam int AW = 12;
  localparam int DW = 256;

  logic          CLK = 1'b0;
  logic          RST, start, ser_in, ser_valid;
  logic [3:0]    feat;
  logic [AW-1:0] num_dp;
  logic [DW-1:0] data;
  logic [AW-1:0] addr;
  logic          we, busy, done, err;

  always #5 CLK = ~CLK;

  ser_row_loader dut (
    .CLK      (CLK),
    .RST      (RST),
    .start    (start),
    .ser_in   (ser_in),
    .ser_valid(ser_valid),
    .feat     (feat),
    .num_dp   (num_dp),
    .data     (data),
    .addr     (addr),
    .we       (we),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  typedef struct {
    int   f;
    int   n;
    int   gmin;
    int   gmax;
    logic exp_err;
  } vec_t;

  vec_t vecs[9];

  int pass_cnt  = 0;
  int total_cnt = 0;
  int t, done_cyc, stab_bad;
  logic busy_start;
  logic [DW-1:0] we_data[$];
  logic [AW-1:0] we_addr[$];
  int            we_cyc[$];
  int            bit_cyc[$];
  logic [L-1:0]  words[$];
  logic [DW-1:0] prev_data;
  logic [AW-1:0] prev_addr;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // One clock; outputs sampled 1 time unit after the rising edge.
  task automatic tick();
    logic r, s;
    r = RST;
    s = start;
    @(posedge CLK);
    #1;
    t++;
    if (we === 1'b1) begin
      we_data.push_back(data);
      we_addr.push_back(addr);
      we_cyc.push_back(t);
    end else if (!r && !s && (data !== prev_data || addr !== prev_addr)) begin
      stab_bad++;
    end
    if (done === 1'b1 && done_cyc < 0) done_cyc = t;
    prev_data = data;
    prev_addr = addr;
  endtask

  task automatic clear_log();
    we_data.delete();
    we_addr.delete();
    we_cyc.delete();
    bit_cyc.delete();
    done_cyc = -1;
    stab_bad = 0;
  endtask

  task automatic gen_words(input int cnt);
    words.delete();
    for (int i = 0; i < cnt; i++) words.push_back(L'($urandom));
  endtask

  // Start a load and stream every bit of 'words'; pulse_at >= 0 re-pulses
  // start (with different feat/num_dp) alongside that bit.
  task automatic drive_load(input int f, input int n, input int gmin, input int gmax,
                            input int pulse_at);
    logic [L-1:0] w;
    clear_log();
    feat = 4'(f);
    num_dp = AW'(n);
    start = 1'b1;
    ser_valid = 1'b0;
    t = 0;
    tick();
    busy_start = busy;
    start = 1'b0;
    for (int b = 0; b < words.size() * L; b++) begin
      w = words[b / L];
      ser_valid = 1'b1;
      ser_in = w[L - 1 - (b % L)];
      if (b == pulse_at) begin
        start = 1'b1;
        feat = 4'd0;
        num_dp = AW'(1);
      end
      bit_cyc.push_back(t);
      tick();
      start = 1'b0;
      ser_valid = 1'b0;
      repeat ($urandom_range(gmax, gmin)) begin
        ser_in = 1'($urandom);
        tick();
      end
    end
    ser_valid = 1'b0;
    for (int i = 0; i < 8 && done_cyc < 0; i++) tick();
  endtask

  task automatic verify_load(input string tag, input int f, input int n, input logic exp_err);
    int rows, last_we, nw;
    logic [DW-1:0] e;
    logic [AW-1:0] fin_addr;
    rows = exp_err ? 0 : n;
    check({tag, " busy_after_start"}, busy_start, !exp_err);
    check({tag, " err"}, err, exp_err);
    check({tag, " done"}, done, 1'b1);
    check({tag, " busy_end"}, busy, 1'b0);
    check({tag, " write_count"}, we_cyc.size(), rows);
    last_we = 0;
    for (int r = 0; r < rows && r < we_cyc.size(); r++) begin
      e = '0;
      for (int k = 0; k <= f; k++) e |= DW'(words[r * (f + 1) + k]) << (L * k);
      last_we = bit_cyc[(r + 1) * (f + 1) * L - 1] + 1;
      check($sformatf("%s row%0d addr", tag, r), we_addr[r], r);
      check($sformatf("%s row%0d data", tag, r), we_data[r], e);
      check($sformatf("%s row%0d we_cycle", tag, r), we_cyc[r], last_we);
    end
    check({tag, " done_cycle"}, done_cyc, exp_err ? 1 : last_we + 1);
    fin_addr = exp_err ? '0 : AW'(n - 1);
    check({tag, " final_addr"}, addr, fin_addr);
    check({tag, " stable_when_idle"}, stab_bad, 0);
    // DONE must ignore serial traffic.
    nw = we_cyc.size();
    repeat (12) begin
      ser_valid = 1'($urandom);
      ser_in = 1'($urandom);
      tick();
    end
    ser_valid = 1'b0;
    check({tag, " no_we_in_done"}, we_cyc.size(), nw);
    check({tag, " done_held"}, done, 1'b1);
    check({tag, " addr_held"}, addr, fin_addr);
  endtask

  initial begin
    vecs[0] = '{f: 0,  n: 1,    gmin: 0, gmax: 0, exp_err: 1'b0};
    vecs[1] = '{f: 15, n: 1,    gmin: 0, gmax: 1, exp_err: 1'b0};
    vecs[2] = '{f: 5,  n: 2,    gmin: 0, gmax: 3, exp_err: 1'b0};
    vecs[3] = '{f: 1,  n: 4,    gmin: 0, gmax: 0, exp_err: 1'b0};
    vecs[4] = '{f: 0,  n: 100,  gmin: 0, gmax: 0, exp_err: 1'b0};
    vecs[5] = '{f: 3,  n: 3,    gmin: 1, gmax: 2, exp_err: 1'b0};
    vecs[6] = '{f: 0,  n: 101,  gmin: 0, gmax: 0, exp_err: 1'b1};
    vecs[7] = '{f: 2,  n: 4095, gmin: 0, gmax: 0, exp_err: 1'b1};
    vecs[8] = '{f: 7,  n: 0,    gmin: 0, gmax: 0, exp_err: 1'b1};

    RST = 1'b1;
    start = 1'b0;
    ser_valid = 1'b0;
    ser_in = 1'b0;
    feat = '0;
    num_dp = '0;
    t = 0;
    clear_log();
    tick();
    tick();
    check("reset data", data, '0);
    check("reset addr", addr, '0);
    check("reset we", we, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset err", err, 1'b0);
    RST = 1'b0;
    tick();

    // Two rows of three words, continuous valid; row 1 bit 0 lands in the we cycle.
    words.delete();
    for (int i = 1; i <= 6; i++) words.push_back(L'(i));
    drive_load(2, 2, 0, 0, -1);
    if (we_cyc.size() >= 2) begin
      check("fixed we0 cycle", we_cyc[0], 49);
      check("fixed we1 cycle", we_cyc[1], 97);
      check("fixed row0 data", we_data[0], DW'(48'h0003_0002_0001));
      check("fixed row1 data", we_data[1], DW'(48'h0006_0005_0004));
      check("fixed row1 word0", we_data[1][15:0], 16'h0004);
    end else begin
      check("fixed we count", we_cyc.size(), 2);
    end
    check("fixed done cycle", done_cyc, 98);
    verify_load("fixed", 2, 2, 1'b0);

    // y-only rows, valid every other cycle.
    gen_words(3);
    drive_load(0, 3, 1, 1, -1);
    verify_load("feat0", 0, 3, 1'b0);

    // Illegal row counts.
    words.delete();
    drive_load(0, 0, 0, 0, -1);
    verify_load("num0", 0, 0, 1'b1);
    drive_load(0, 101, 0, 0, -1);
    verify_load("num101", 0, 101, 1'b1);

    // Reset 20 bits into a row, then a clean one-row load.
    clear_log();
    feat = 4'd2;
    num_dp = AW'(3);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      ser_valid = 1'b1;
      ser_in = 1'($urandom);
      tick();
    end
    RST = 1'b1;
    ser_valid = 1'b1;
    start = 1'b1;
    tick();
    RST = 1'b0;
    ser_valid = 1'b0;
    start = 1'b0;
    check("rst_mid data", data, '0);
    check("rst_mid addr", addr, '0);
    check("rst_mid we", we, 1'b0);
    check("rst_mid busy", busy, 1'b0);
    check("rst_mid done", done, 1'b0);
    check("rst_mid err", err, 1'b0);
    check("rst_mid no_write", we_cyc.size(), 0);
    gen_words(2);
    drive_load(1, 1, 0, 0, -1);
    verify_load("after_rst", 1, 1, 1'b0);

    // start pulsed mid-load must be ignored.
    gen_words(6);
    drive_load(1, 3, 0, 2, 40);
    verify_load("mid_start", 1, 3, 1'b0);

    // Randomised table.
    foreach (vecs[i]) begin
      gen_words(vecs[i].exp_err ? 0 : (vecs[i].f + 1) * vecs[i].n);
      drive_load(vecs[i].f, vecs[i].n, vecs[i].gmin, vecs[i].gmax, -1);
      verify_load($sformatf("vec%0d", i), vecs[i].f, vecs[i].n, vecs[i].exp_err);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/ser_row_loader.md
SER_ROW_LOADER -- requirements
Module: ser_row_loader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, meaning the RAM address width.
REQ-002 SHALL have parameter MAX_FEATURES, default 15, meaning the maximum number of feature words per row.
REQ-003 SHALL have parameter LENGTH, default 16, meaning the bits per word.
REQ-004 SHALL have parameter DATA_WIDTH, default LENGTH*(MAX_FEATURES+1), meaning the row width (features plus y).
REQ-005 SHALL have parameter DEPTH, default 100, meaning the maximum number of rows the RAM holds.
REQ-006 SHALL have port CLK, input, 1 bit: rising-edge clock.
REQ-007 SHALL have port RST, input, 1 bit: reset, synchronous, active-high.
REQ-008 SHALL have port start, input, 1 bit: one-cycle pulse that begins a load.
REQ-009 SHALL have port ser_in, input, 1 bit: serial data bit, MSB-first per word.
REQ-010 SHALL have port ser_valid, input, 1 bit: ser_in is sampled only when this is high.
REQ-011 SHALL have port feat, input, 4 bits: number of features, sampled at start.
REQ-012 SHALL have port num_dp, input, ADDR_WIDTH bits: number of rows, sampled at start.
REQ-013 SHALL have port data, output, DATA_WIDTH bits: assembled row presented to the RAM.
REQ-014 SHALL have port addr, output, ADDR_WIDTH bits: RAM row address.
REQ-015 SHALL have port we, output, 1 bit: one-cycle RAM write strobe.
REQ-016 SHALL have port busy, output, 1 bit: high while in the LOAD state.
REQ-017 SHALL have port done, output, 1 bit: load complete; held high.
REQ-018 SHALL have port err, output, 1 bit: num_dp is illegal; held high with done.

Function
REQ-019 SHALL implement a state machine with states IDLE, LOAD and DONE; RST forces IDLE.
REQ-020 SHALL, in IDLE on start=1, latch feat and num_dp, clear all counters and go to LOAD.
REQ-021 SHALL, in IDLE on start=1 with num_dp=0 or num_dp>DEPTH, set err=1 and go to DONE without issuing any we.
REQ-022 SHALL, in LOAD, shift ser_in into a LENGTH-bit word register on each ser_valid=1; the first bit received is the word MSB.
REQ-023 SHALL, on the LENGTH-th valid bit, copy the word into slot k at data[LENGTH*k +: LENGTH]; k = 0..feat; slots 0..feat-1 hold features, slot feat holds y.
REQ-024 SHALL keep slots above feat at zero; feat=0 gives one word (y only) per row.
REQ-025 SHALL assert we for exactly one cycle, in the cycle after the last bit of word feat, with data = the completed row and addr = the row index.
REQ-026 SHALL clear the row register and advance the row index in the cycle after we; a ser_valid bit arriving in the we cycle SHALL be accepted as bit 0 of the next row.
REQ-027 SHALL hold data and addr stable whenever we=0.
REQ-028 SHALL use a row index that runs 0..num_dp-1 and never wraps.
REQ-029 SHALL go from LOAD to DONE in the cycle after the we for row num_dp-1.
REQ-030 SHALL, in DONE, hold done=1 and hold addr at num_dp-1, or at 0 when err=1; ser_valid SHALL be ignored.
REQ-031 SHALL, in DONE, clear done and err on start=1 and re-evaluate the new start exactly as in IDLE.
REQ-032 SHALL ignore start while in LOAD.
REQ-033 SHALL treat feat values above MAX_FEATURES as MAX_FEATURES.

Reset
REQ-034 SHALL, on RST=1 at a clock edge, set state=IDLE and data, addr, we, busy, done, err and all counters to 0.
REQ-035 SHALL let RST during LOAD abort the load; a partial row SHALL NOT be written.
REQ-036 SHALL give RST priority over start and ser_valid in the same cycle.

Structure
REQ-037 SHALL take the state encodings (IDLE=0, LOAD=1, DONE=2) and the default parameter values from a shared package, linreg_pkg, common to the loader, RAM and SGD blocks.
REQ-038 SHALL contain one sub-module, ser_word_shift (LENGTH-bit shift register plus bit counter, word_done pulse); row assembly and the FSM SHALL stay in ser_row_loader.

Verification
REQ-039 SHALL cover: feat=2, num_dp=2, continuous ser_valid, words 0x0001,0x0002,0x0003 / 0x0004,0x0005,0x0006 -> we at cycles 49 and 97 after start; row0 data[47:0]=0x0003_0002_0001 at addr 0; row1 at addr 1; done one cycle after the second we.
REQ-040 SHALL cover: feat=0, num_dp=3, ser_valid high every other cycle -> three we pulses, each with only data[15:0] non-zero; addr 0,1,2.
REQ-041 SHALL cover: start with num_dp=0, then with num_dp=101 -> err=1 and done=1 on the next cycle; no we.
REQ-042 SHALL cover: RST asserted after 20 bits of a row -> all outputs 0 on the next cycle; a restart with num_dp=1 writes only the new row at addr 0.
REQ-043 SHALL cover: a ser_valid bit in the we cycle -> accepted as the MSB of the next row's word 0, with no bit lost.
REQ-044 SHALL cover: start pulsed mid-LOAD -> ignored; row count and addresses unchanged.
